// File: rtl/ring_node.sv
// ---------------------------------------------------------------------------
// ring_node -- one stop on a unidirectional packet ring.
//
// Each node sits between an upstream and a downstream neighbour and serves one
// local processing unit. Traffic already on the ring always wins: a packet
// addressed to this node is delivered to the local unit and taken off the ring.
// Any other packet is passed downstream after one register stage. Packets from
// the local unit wait in a small inject FIFO. Each one goes onto the ring in a
// cycle where the ring slot would otherwise be empty.
//
// Packet layout (MSB..LSB): {valid, dst[1:0], port[PW-1:0], data[DW-1:0]}.
// Any packet whose valid bit is clear is driven as all zeros.
//
// Parameters
//   NODE   node id of the attached unit
//   DW     payload data width
//   PW     port field width
//   DEPTH  inject FIFO entries (power of two, >= 2)
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous reset, active low
//   tx_in     packet from the local unit (valid for one cycle per packet)
//   rx_out    registered packet to the local unit
//   ring_in   packet from the upstream node
//   ring_out  registered packet to the downstream node
//   busy      inject FIFO holds at least one packet (combinational)
//   ovf       sticky; a tx_in packet was dropped on a full FIFO
//
// Build option
//   RING_LOOPBACK_EN  When this is defined, a FIFO head addressed to this node
//                     goes straight to rx_out. It does not travel the whole
//                     ring. It goes only in a cycle with no ring delivery.
//                     Otherwise the head waits, and ring_out stays free for
//                     forwarding.
// ---------------------------------------------------------------------------
module ring_node #(
   parameter logic [1:0] NODE  = 2'd0,
   parameter int         DW    = 32,
   parameter int         PW    = 4,
   parameter int         DEPTH = 4,
   localparam int        P     = 1 + 2 + PW + DW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [P-1:0] tx_in,
   output logic [P-1:0] rx_out,
   input  logic [P-1:0] ring_in,
   output logic [P-1:0] ring_out,
   output logic         busy,
   output logic         ovf
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic          vld;
      logic [1:0]    dst;
      logic [PW-1:0] port;
      logic [DW-1:0] data;
   } pkt_t;

   // inject FIFO storage and bookkeeping
   logic [P-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   pkt_t rin, tin, head;
   logic ring_hit, ring_fwd, nonempty, full;
   logic pop_ring, pop_loop, pop, push, drop;

   assign rin  = ring_in;
   assign tin  = tx_in;
   assign head = mem[rd_ptr];

   assign nonempty = (count != '0);
   assign full     = (count == CNT_FULL);
   assign busy     = nonempty;

   // ring traffic has priority over injection
   assign ring_hit = rin.vld && (rin.dst == NODE);
   assign ring_fwd = rin.vld && (rin.dst != NODE);

`ifdef RING_LOOPBACK_EN
   // A local head never goes onto the ring. It leaves only through rx_out,
   // and only in a cycle when rx_out is not already taken by a ring delivery.
   logic head_local;
   assign head_local = nonempty && (head.dst == NODE);
   assign pop_ring   = nonempty && !ring_fwd && !head_local;
   assign pop_loop   = head_local && !ring_hit;
`else
   assign pop_ring   = nonempty && !ring_fwd;
   assign pop_loop   = 1'b0;
`endif

   assign pop  = pop_ring || pop_loop;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push = tin.vld && (!full || pop);
   assign drop = tin.vld && full && !pop;

   // Storage has no reset. The contents matter only below count, and count
   // is cleared by reset.
   always_ff @(posedge clk) begin
      if (rst && push)
         mem[wr_ptr] <= tin;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ring_out <= '0;
         rx_out   <= '0;
         ovf      <= 1'b0;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (ring_fwd)
            ring_out <= rin;
         else if (pop_ring)
            ring_out <= head;
         else
            ring_out <= '0;

         if (ring_hit)
            rx_out <= rin;
         else if (pop_loop)
            rx_out <= head;
         else
            rx_out <= '0;

         // DEPTH is a power of two, so the pointers wrap for free
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         if (drop)
            ovf <= 1'b1;
      end
   end

endmodule

// File: doc/ring_node.md
RING_NODE -- requirements
Module: ring_node

Interface
REQ-001 SHALL have parameter NODE, default 2'd0: node id of the attached processing unit.
REQ-002 SHALL have parameter DW, default 32: payload data width.
REQ-003 SHALL have parameter PW, default 4: port field width.
REQ-004 SHALL have parameter DEPTH, default 4, power of two >=2: inject FIFO entries.
REQ-005 SHALL use packet width P = 1+2+PW+DW, laid out MSB..LSB as {valid, dst[1:0], port[PW-1:0], data[DW-1:0]}.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port tx_in  input  P  packet from local unit tx; valid for one cycle per packet.
REQ-009 SHALL have port rx_out  output  P  packet to local unit rx.
REQ-010 SHALL have port ring_in  input  P  packet from upstream node.
REQ-011 SHALL have port ring_out  output  P  packet to downstream node.
REQ-012 SHALL have port busy  output  1  inject FIFO non-empty.
REQ-013 SHALL have port ovf  output  1  sticky inject-overflow flag.

Function
REQ-014 SHALL register ring_out and rx_out; an invalid packet is driven as all-zero.
REQ-015 SHALL give ring_in priority: a valid ring_in with dst==NODE is placed on rx_out next cycle and not forwarded.
REQ-016 SHALL forward a valid ring_in with dst!=NODE unchanged to ring_out next cycle (one cycle per hop).
REQ-017 SHALL, when ring_in is invalid or consumed locally and the FIFO is non-empty, pop the FIFO head onto ring_out next cycle.
REQ-018 SHALL push every valid tx_in into the FIFO tail in the cycle it is presented.
REQ-019 SHALL, on push while full with no pop the same cycle, drop tx_in, leave FIFO unchanged, and set ovf to 1.
REQ-020 SHALL accept a push while full when a pop occurs the same cycle; count unchanged.
REQ-021 SHALL keep FIFO order strict; read and write pointers wrap modulo DEPTH.
REQ-022 SHALL hold rx_out valid for exactly one cycle per delivered packet.
REQ-023 SHALL clear ovf only by reset.
REQ-024 SHALL drive busy combinationally from FIFO count != 0.

Reset
REQ-025 SHALL, when rst==0 at a clock edge, clear ring_out, rx_out, ovf, FIFO count and both pointers.
REQ-026 SHALL discard FIFO contents and in-flight outputs on reset mid-operation; no packet emitted in the cycle after reset.
REQ-027 SHALL ignore tx_in and ring_in in any cycle where rst==0.

Configuration
REQ-028 SHALL support macro RING_LOOPBACK_EN.
REQ-029 SHALL, with RING_LOOPBACK_EN defined, deliver a FIFO head with dst==NODE to rx_out instead of ring_out, only in cycles with no ring_in delivery; otherwise the head waits, and ring_out stays available for ring_in forwarding.
REQ-030 SHALL, without RING_LOOPBACK_EN, treat dst==NODE heads like any other: inject onto ring_out; delivered when they return via ring_in.

Verification
REQ-031 SHALL cover: NODE=0, idle ring, tx_in={1,2'd2,4'h3,32'hDEADBEEF} at cycle 0 -> ring_out equals it at cycle 2, busy high cycle 1 only.
REQ-032 SHALL cover: ring_in valid dst=0 data 32'h1234 -> rx_out valid one cycle later, ring_out zero.
REQ-033 SHALL cover: ring_in valid dst=1 every cycle for 10 cycles plus 3 tx_in pushes -> ring_out forwards all 10 in order, then 3 injected in push order.
REQ-034 SHALL cover: DEPTH=4, continuous ring traffic, 5 pushes -> 5th dropped, ovf=1 from next cycle until reset; then full FIFO with simultaneous push+pop -> push accepted, ovf unchanged.
REQ-035 SHALL cover: RING_LOOPBACK_EN defined, tx_in dst=NODE data 32'h55 -> rx_out valid 2 cycles later, ring_out zero; with a same-cycle ring_in delivery -> loopback delayed one cycle.
REQ-036 SHALL cover: rst=0 for one cycle with 3 FIFO entries -> busy=0, ovf=0, outputs zero next cycle; no stale packet emitted afterwards.
